// File: rtl/difftest_aia_pkg.sv
// Shared types for the difftest AIA event channel: one snapshot of the four
// interrupt-file outputs, packed so it can be compared and stored as one word.
package difftest_aia_pkg;

    localparam int AIA_EVENT_W = 256;

    typedef struct packed {
        logic [63:0] mtopei;
        logic [63:0] stopei;
        logic [63:0] vstopei;
        logic [63:0] hgeip;
    } aia_event_t;

endpackage

// File: rtl/difftest_aia_event_fifo.sv
// Event FIFO, DEPTH entries of aia_event_t, head read combinationally from storage.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push_i must only be asserted when not full or popping; ovwr_i replaces the youngest entry.
module difftest_aia_event_fifo
    import difftest_aia_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic       ovwr_i,
    input  logic       pop_i,
    input  aia_event_t wdata_i,
    output aia_event_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx, last_idx;
    aia_event_t    mem_q [DEPTH];

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign last_idx = wr_idx - AW'(1);

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign rdata_o = mem_q[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_idx] <= wdata_i;
        end else if (ovwr_i) begin
            mem_q[last_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/difftest_aia_event_gen.sv
// AIA event producer: snapshots mtopei/stopei/vstopei/hgeip into a FIFO for the difftest sink.
// Latency: 1 cycle sample-to-out_valid; one event per cycle with out_ready high.
// Backpressure: full FIFO without a pop coalesces into the youngest entry and bumps ovf_count.
// DIFFTEST_AIA_DEDUP_EN: push only when the snapshot differs from the last pushed one.
module difftest_aia_event_gen
    import difftest_aia_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] CORE_ID = 8'd0,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [63:0]      in_mtopei,
    input  logic [63:0]      in_stopei,
    input  logic [63:0]      in_vstopei,
    input  logic [63:0]      in_hgeip,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [63:0]      out_mtopei,
    output logic [63:0]      out_stopei,
    output logic [63:0]      out_vstopei,
    output logic [63:0]      out_hgeip,
    output logic [7:0]       out_coreid,
    output logic [CNT_W-1:0] ovf_count
);

    aia_event_t       snap, head;
    logic             push_req, push, ovwr, pop, full, empty;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    assign snap = '{mtopei: in_mtopei, stopei: in_stopei, vstopei: in_vstopei, hgeip: in_hgeip};

`ifdef DIFFTEST_AIA_DEDUP_EN
    aia_event_t shadow_q;

    assign push_req = sample_en && (snap != shadow_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (push_req) begin
            shadow_q <= snap;
        end
    end
`else
    assign push_req = sample_en;
`endif

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign ovwr      = push_req && full && !pop;
    assign push      = push_req && !ovwr;

    difftest_aia_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .ovwr_i  (ovwr),
        .pop_i   (pop),
        .wdata_i (snap),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (ovwr && (ovf_q != '1)) ovf_d = ovf_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Storage is not reset, so the data outputs are forced to zero while empty.
    assign out_mtopei  = empty ? 64'd0 : head.mtopei;
    assign out_stopei  = empty ? 64'd0 : head.stopei;
    assign out_vstopei = empty ? 64'd0 : head.vstopei;
    assign out_hgeip   = empty ? 64'd0 : head.hgeip;
    assign out_coreid  = CORE_ID;
    assign ovf_count   = ovf_q;

endmodule

// File: tb/tb_difftest_aia_event_gen.sv
// Directed bench for difftest_aia_event_gen with a queue scoreboard of expected events.
module tb_difftest_aia_event_gen;
    import difftest_aia_pkg::*;

    localparam int         DEPTH   = 4;
    localparam logic [7:0] CORE_ID = 8'hA5;
    localparam int         CNT_W   = 16;

    logic             clock;
    logic             reset;
    logic             sample_en;
    logic [63:0]      in_mtopei, in_stopei, in_vstopei, in_hgeip;
    logic             out_ready;
    logic             out_valid;
    logic [63:0]      out_mtopei, out_stopei, out_vstopei, out_hgeip;
    logic [7:0]       out_coreid;
    logic [CNT_W-1:0] ovf_count;

    difftest_aia_event_gen #(
        .DEPTH   (DEPTH),
        .CORE_ID (CORE_ID),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_en   (sample_en),
        .in_mtopei   (in_mtopei),
        .in_stopei   (in_stopei),
        .in_vstopei  (in_vstopei),
        .in_hgeip    (in_hgeip),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_mtopei  (out_mtopei),
        .out_stopei  (out_stopei),
        .out_vstopei (out_vstopei),
        .out_hgeip   (out_hgeip),
        .out_coreid  (out_coreid),
        .ovf_count   (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef DIFFTEST_AIA_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    int               n_checks = 0;
    int               n_fail   = 0;
    aia_event_t       exp_q [$];
    aia_event_t       m_shadow;
    logic [CNT_W-1:0] m_ovf;

    function automatic aia_event_t mk(input logic [63:0] m, input logic [63:0] s,
                                      input logic [63:0] v, input logic [63:0] h);
        aia_event_t e;
        e.mtopei  = m;
        e.stopei  = s;
        e.vstopei = v;
        e.hgeip   = h;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at the falling edge: compares the state produced by the previous rising edge.
    task automatic check_outputs();
        logic       ev;
        aia_event_t eh;
        ev = (exp_q.size() != 0);
        eh = ev ? exp_q[0] : '0;
        chk("out_valid", {255'd0, out_valid}, {255'd0, ev});
        chk("head", {out_mtopei, out_stopei, out_vstopei, out_hgeip}, eh);
        chk("ovf_count", {{(256-CNT_W){1'b0}}, ovf_count}, {{(256-CNT_W){1'b0}}, m_ovf});
        chk("out_coreid", {248'd0, out_coreid}, {248'd0, CORE_ID});
    endtask

    task automatic step(input logic se, input aia_event_t s, input logic rdy);
        logic pop, do_push, full_before;
        check_outputs();
        sample_en  = se;
        in_mtopei  = s.mtopei;
        in_stopei  = s.stopei;
        in_vstopei = s.vstopei;
        in_hgeip   = s.hgeip;
        out_ready  = rdy;
        pop         = (exp_q.size() != 0) && rdy;
        full_before = (exp_q.size() == DEPTH);
        do_push     = se && (!DEDUP || (s != m_shadow));
        if (do_push && full_before && !pop) begin
            exp_q[exp_q.size()-1] = s;
            if (m_ovf != {CNT_W{1'b1}}) m_ovf = m_ovf + 1'b1;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(s);
        end
        if (do_push) m_shadow = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset(input aia_event_t s);
        check_outputs();
        reset      = 1'b1;
        sample_en  = 1'b1;
        in_mtopei  = s.mtopei;
        in_stopei  = s.stopei;
        in_vstopei = s.vstopei;
        in_hgeip   = s.hgeip;
        out_ready  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        m_shadow = '0;
        m_ovf    = '0;
    endtask

    initial begin
        aia_event_t last;
        reset     = 1'b1;
        sample_en = 1'b0;
        in_mtopei = '0; in_stopei = '0; in_vstopei = '0; in_hgeip = '0;
        out_ready = 1'b0;
        m_shadow  = '0;
        m_ovf     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // First event: mtopei=0x0B, others zero, one-cycle latency.
        step(1'b0, mk(64'h0, 64'h0, 64'h0, 64'h0), 1'b0);
        step(1'b1, mk(64'h0B, 64'h0, 64'h0, 64'h0), 1'b0);
        step(1'b0, mk(64'h0B, 64'h0, 64'h0, 64'h0), 1'b0);
        step(1'b0, mk(64'h0B, 64'h0, 64'h0, 64'h0), 1'b1);

        // Same snapshot held for 10 sampled cycles.
        for (int i = 0; i < 10; i++) step(1'b1, mk(64'h22, 64'h7, 64'h0, 64'h1), 1'b1);
        repeat (2) step(1'b0, mk(64'h22, 64'h7, 64'h0, 64'h1), 1'b1);

        // Fill with 5 distinct snapshots while stalled: 5 coalesces into the youngest.
        for (int k = 1; k <= 5; k++) step(1'b1, mk(64'(k), 64'h0, 64'h0, 64'h0), 1'b0);
        // Full, pop and a new snapshot in the same cycle: plain push, no coalesce.
        step(1'b1, mk(64'h6, 64'h0, 64'h0, 64'h0), 1'b1);
        repeat (6) step(1'b0, mk(64'h6, 64'h0, 64'h0, 64'h0), 1'b1);

        // Reset with 3 pending, then re-present the last snapshot.
        for (int k = 1; k <= 3; k++) step(1'b1, mk(64'h100 + 64'(k), 64'h0, 64'hF, 64'h0), 1'b0);
        last = mk(64'h103, 64'h0, 64'hF, 64'h0);
        do_reset(mk(64'hDEAD, 64'hBEEF, 64'h0, 64'h0));
        step(1'b1, last, 1'b0);
        repeat (2) step(1'b0, last, 1'b1);

        // Toggling out_ready with a fresh snapshot every cycle.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, mk({32'($urandom), 32'(i)}, 64'($urandom), 64'($urandom), 64'(i)), 1'(i % 2 == 0));
        end
        repeat (8) step(1'b0, mk(64'h0, 64'h0, 64'h0, 64'h0), 1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
